// File: rtl/cfs_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cfs_rx_ctrl
// Description : MD receive-side controller. It accepts one MD transfer at a
//               time and checks it for legality. A legal transfer is pushed
//               into the RX FIFO and answered with an OK response. An
//               illegal transfer is answered with an error response and
//               counted in a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cfs_rx_ctrl #(
   parameter  int ALGN_DATA_WIDTH   = 32,
   localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH/8),
   localparam int ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH/8) + 1,
   localparam int FIFO_WIDTH        = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   // MD slave side
   input  logic                         md_rx_valid,
   input  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
   input  logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset,
   input  logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size,
   output logic                         md_rx_ready,
   output logic                         md_rx_err,
   // RX FIFO push side
   output logic                         push_valid,
   output logic [FIFO_WIDTH-1:0]        push_data,
   input  logic                         push_ready,
   // Drop statistics
   input  logic                         drop_cnt_clr,
   output logic [7:0]                   drop_cnt
);

   // Legality arithmetic runs one bit wider than the size field so that
   // offset+size and bytes+offset can never wrap.
   localparam int                   LEG_W        = ALGN_SIZE_WIDTH + 1;
   localparam logic [LEG_W-1:0]     C_NUM_BYTES  = LEG_W'(ALGN_DATA_WIDTH/8);
   localparam logic [LEG_W-1:0]     C_ONE        = LEG_W'(1);
   localparam logic [7:0]           C_DROP_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PUSH     = 2'd1,
      ST_RESP_OK  = 2'd2,
      ST_RESP_ERR = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    w_capture;
   logic [FIFO_WIDTH-1:0]   r_push_data;
   logic [7:0]              r_drop_cnt;

   logic [LEG_W-1:0]        w_off_ext;
   logic [LEG_W-1:0]        w_size_ext;
   logic [LEG_W-1:0]        w_end;
   logic [LEG_W-1:0]        w_span;
   logic [LEG_W-1:0]        w_divisor;
   logic [LEG_W-1:0]        w_rem;
   logic                    w_size_nz;
   logic                    w_legal;

   // Legality check of the request currently presented on the MD inputs:
   // non-zero size, the window fits in the bus, and the window is aligned
   // to its own size relative to the bus width.
   always_comb begin
      w_off_ext  = LEG_W'(md_rx_offset);
      w_size_ext = LEG_W'(md_rx_size);
      w_size_nz  = (w_size_ext != '0);
      w_end      = w_off_ext + w_size_ext;
      w_span     = C_NUM_BYTES + w_off_ext;
      // Divisor forced to 1 for size 0 so the remainder is always defined;
      // size 0 is rejected separately by w_size_nz.
      w_divisor  = w_size_nz ? w_size_ext : C_ONE;
      w_rem      = w_span % w_divisor;
      w_legal    = w_size_nz && (w_end <= C_NUM_BYTES) && (w_rem == '0);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and output decode. All handshake outputs are pure state
   // decodes, so each response lasts exactly one cycle and push_valid can
   // only fall after a handshake or a reset.
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      push_valid   = 1'b0;
      md_rx_ready  = 1'b0;
      md_rx_err    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (md_rx_valid) begin
               w_capture    = 1'b1;
               w_next_state = w_legal ? ST_PUSH : ST_RESP_ERR;
            end
         end
         ST_PUSH: begin
            push_valid = 1'b1;
            if (push_ready) begin
               w_next_state = ST_RESP_OK;
            end
         end
         ST_RESP_OK: begin
            md_rx_ready  = 1'b1;
            w_next_state = ST_IDLE;
         end
         ST_RESP_ERR: begin
            md_rx_ready  = 1'b1;
            md_rx_err    = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Capture the request in IDLE; the word is held stable through PUSH
   // because MD inputs are not looked at again until the next IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_push_data <= '0;
      end else if (w_capture) begin
         r_push_data <= {md_rx_size, md_rx_offset, md_rx_data};
      end
   end

   // Saturating drop counter; a clear in the same cycle as an increment wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_cnt <= '0;
      end else if (drop_cnt_clr) begin
         r_drop_cnt <= '0;
      end else if ((r_state == ST_RESP_ERR) && (r_drop_cnt != C_DROP_MAX)) begin
         r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign push_data = r_push_data;
   assign drop_cnt  = r_drop_cnt;

   // Protocol invariants of the two handshake interfaces.
   a_no_ready_and_push : assert property (@(posedge clk) disable iff (reset)
      !(md_rx_ready && push_valid));
   a_err_only_with_ready : assert property (@(posedge clk) disable iff (reset)
      (md_rx_err |-> md_rx_ready));
   a_push_held : assert property (@(posedge clk) disable iff (reset)
      (push_valid && !push_ready) |=> (push_valid && $stable(push_data)));

endmodule
`default_nettype wire

// File: tb/tb_cfs_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfs_rx_ctrl
// Description : Self-checking bench for cfs_rx_ctrl (32-bit bus). Random and
//               directed MD transfers are compared cycle by cycle with a
//               transfer-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfs_rx_ctrl;

   localparam int W  = 32;
   localparam int OW = 2;
   localparam int SW = 3;
   localparam int FW = W + OW + SW;

   logic          clk = 1'b0;
   logic          reset;
   logic          md_rx_valid;
   logic [W-1:0]  md_rx_data;
   logic [OW-1:0] md_rx_offset;
   logic [SW-1:0] md_rx_size;
   logic          md_rx_ready;
   logic          md_rx_err;
   logic          push_valid;
   logic [FW-1:0] push_data;
   logic          push_ready;
   logic          drop_cnt_clr;
   logic [7:0]    drop_cnt;

   int n_cmp    = 0;
   int n_bad    = 0;
   int exp_drop = 0;

   cfs_rx_ctrl #(.ALGN_DATA_WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .md_rx_valid  (md_rx_valid),
      .md_rx_data   (md_rx_data),
      .md_rx_offset (md_rx_offset),
      .md_rx_size   (md_rx_size),
      .md_rx_ready  (md_rx_ready),
      .md_rx_err    (md_rx_err),
      .push_valid   (push_valid),
      .push_data    (push_data),
      .push_ready   (push_ready),
      .drop_cnt_clr (drop_cnt_clr),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference legality rule on a 4-byte bus, in plain integer arithmetic.
   function automatic bit legal_m(input int off, input int sz);
      return (sz != 0) && (off + sz <= 4) && (((4 + off) % sz) == 0);
   endfunction

   // Idle cycles with the MD request low; occasionally clears the counter.
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         chk("gap_ready", 64'(md_rx_ready), 64'd0);
         chk("gap_err",   64'(md_rx_err),   64'd0);
         chk("gap_pv",    64'(push_valid),  64'd0);
         chk("gap_drop",  64'(drop_cnt),    64'(exp_drop));
         md_rx_valid  = 1'b0;
         drop_cnt_clr = ($urandom_range(0, 15) == 0);
         if (drop_cnt_clr) exp_drop = 0;
         @(negedge clk);
         drop_cnt_clr = 1'b0;
      end
   endtask

   // One MD transfer. Entered at the falling edge of an IDLE cycle, leaves
   // at the falling edge of the IDLE cycle that follows the response.
   task automatic xfer(input int off, input int sz, input logic [31:0] data,
                       input int stall, input bit hold, input bit clr_err);
      logic [63:0] wexp;
      bit          lg;
      lg   = legal_m(off, sz);
      wexp = (64'(sz) << 34) | (64'(off) << 32) | 64'(data);
      chk("idle_ready", 64'(md_rx_ready), 64'd0);
      chk("idle_pv",    64'(push_valid),  64'd0);
      chk("idle_drop",  64'(drop_cnt),    64'(exp_drop));
      md_rx_valid  = 1'b1;
      md_rx_offset = OW'(off);
      md_rx_size   = SW'(sz);
      md_rx_data   = data;
      push_ready   = 1'b0;
      @(negedge clk);
      if (lg) begin
         for (int i = 0; i <= stall; i++) begin
            chk("push_valid",    64'(push_valid),  64'd1);
            chk("push_data",     64'(push_data),   wexp);
            chk("ready_in_push", 64'(md_rx_ready), 64'd0);
            // MD inputs are don't-care while the transfer is in flight.
            md_rx_valid  = 1'($urandom);
            md_rx_offset = OW'($urandom);
            md_rx_size   = SW'($urandom);
            md_rx_data   = $urandom;
            push_ready   = (i == stall);
            @(negedge clk);
         end
         push_ready = 1'b0;
         chk("ok_ready", 64'(md_rx_ready), 64'd1);
         chk("ok_err",   64'(md_rx_err),   64'd0);
         chk("ok_pv",    64'(push_valid),  64'd0);
      end else begin
         chk("err_ready", 64'(md_rx_ready), 64'd1);
         chk("err_err",   64'(md_rx_err),   64'd1);
         chk("err_pv",    64'(push_valid),  64'd0);
         drop_cnt_clr = clr_err;
         if (clr_err)             exp_drop = 0;
         else if (exp_drop < 255) exp_drop = exp_drop + 1;
      end
      md_rx_valid = hold;
      @(negedge clk);
      drop_cnt_clr = 1'b0;
   endtask

   initial begin
      int off, sz, stall;
      bit hold;
      reset        = 1'b1;
      md_rx_valid  = 1'b0;
      md_rx_data   = '0;
      md_rx_offset = '0;
      md_rx_size   = '0;
      push_ready   = 1'b0;
      drop_cnt_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pv",    64'(push_valid),  64'd0);
      chk("rst_ready", 64'(md_rx_ready), 64'd0);
      chk("rst_err",   64'(md_rx_err),   64'd0);
      chk("rst_data",  64'(push_data),   64'd0);
      chk("rst_drop",  64'(drop_cnt),    64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Aligned full-word transfer.
      xfer(0, 4, 32'hDDCCBBAA, 0, 1'b0, 1'b0);
      // One legal and three illegal shapes.
      xfer(2, 2, 32'h11223344, 0, 1'b0, 1'b0);
      xfer(1, 2, 32'h55667788, 0, 1'b0, 1'b0);
      xfer(3, 2, 32'h99AABBCC, 0, 1'b0, 1'b0);
      xfer(1, 0, 32'hDEADBEEF, 0, 1'b0, 1'b0);
      chk("drop_three", 64'(drop_cnt), 64'd3);
      // Back-pressure of five cycles.
      xfer(0, 4, 32'hCAFEF00D, 5, 1'b0, 1'b0);
      gap(1);

      // Random traffic.
      for (int t = 0; t < 150; t++) begin
         off = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 2))
               0:       sz = 1;
               1:       sz = 2;
               default: sz = 4;
            endcase
         end else begin
            sz = $urandom_range(0, 7);
         end
         stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
         hold  = 1'($urandom_range(0, 1));
         xfer(off, sz, $urandom, stall, hold, ($urandom_range(0, 7) == 0));
         if (!hold) gap($urandom_range(0, 2));
      end

      // Counter saturation, then clear racing an increment.
      for (int t = 0; t < 300; t++) begin
         xfer($urandom_range(0, 3), 0, $urandom, 0, 1'b1, 1'b0);
      end
      chk("drop_sat", 64'(drop_cnt), 64'd255);
      xfer(1, 2, 32'h0BADF00D, 0, 1'b0, 1'b1);
      chk("drop_clr", 64'(drop_cnt), 64'd0);

      // Back-to-back legal transfers with the request held high.
      for (int t = 0; t < 5; t++) begin
         xfer(0, 4, $urandom, 0, (t != 4), 1'b0);
      end
      xfer(3, 0, 32'h0, 0, 1'b0, 1'b0);

      // Reset while a push is pending.
      md_rx_valid  = 1'b1;
      md_rx_offset = 2'd0;
      md_rx_size   = 3'd4;
      md_rx_data   = 32'h12345678;
      push_ready   = 1'b0;
      @(negedge clk);
      chk("pre_rst_pv", 64'(push_valid), 64'd1);
      reset       = 1'b1;
      md_rx_valid = 1'b0;
      @(negedge clk);
      reset    = 1'b0;
      exp_drop = 0;
      chk("mid_rst_pv",   64'(push_valid), 64'd0);
      chk("mid_rst_data", 64'(push_data),  64'd0);
      chk("mid_rst_drop", 64'(drop_cnt),   64'd0);
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_ready", 64'(md_rx_ready), 64'd0);
         chk("post_rst_pv",    64'(push_valid),  64'd0);
         @(negedge clk);
      end
      xfer(2, 2, 32'hA5A5A5A5, 2, 1'b0, 1'b0);
      gap(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
